display_framebuffer: RTL and testbench
======================================

Name: display_framebuffer

Overview:
Double-buffered pixel store for the LED panel driver. It is the next generation of the single-port flip memory. The host writes into the back buffer while the scan-out engine reads the front buffer. It adds:
- per-channel write masking
- a hardware clear engine that fills the back buffer
- a flip request that is applied only at a frame boundary, with a handshake back to the host.

Parameters:
ROWS, 8, panel rows; need not be a power of two.
COLUMNS, 32, panel columns; need not be a power of two.
CHANNELS, 3, colour channels per pixel.
CHANNEL_WIDTH, 8, bits per channel; pixel width W = CHANNELS*CHANNEL_WIDTH.
RW = $clog2(ROWS), CW = $clog2(COLUMNS), derived, not overridable.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  reset, asynchronous, active-high.
wen  in  1  back-buffer write strobe.
wrow  in  RW  write row.
wcol  in  CW  write column.
wdata  in  W  write pixel; channel k occupies bits [k*CHANNEL_WIDTH +: CHANNEL_WIDTH].
wmask  in  CHANNELS  per-channel write enable.
wready  out  1  high when host writes are accepted.
clear_req  in  1  pulse: fill the back buffer with clear_value.
clear_value  in  W  fill pixel, sampled on the accepted clear_req.
busy  out  1  clear engine active.
flip_req  in  1  pulse: request a swap of front and back.
frame_end  in  1  pulse from scan-out marking a frame boundary.
flip_pending  out  1  a flip is requested but not yet applied.
flip_done  out  1  one-cycle pulse on the cycle front toggles.
front  out  1  index of the current front buffer.
ren  in  1  front-buffer read strobe.
rrow  in  RW  read row.
rcol  in  CW  read column.
rdata  out  W  registered read data.
rvalid  out  1  rdata valid, one cycle after ren.

Behaviour:
- Reset values: front=0, flip_pending=0, flip_done=0, busy=0, wready=1, rdata=0, rvalid=0; clear FSM in IDLE.
- Memory contents are not touched by reset. Reset asserted mid-clear aborts the clear, leaving the buffer partially filled.
- Storage: 2*2^(RW+CW) words of W bits, addressed {buf, row, col}. Back buffer is buf = !front.
- Out-of-range row/column indices (>= ROWS or >= COLUMNS) write into unused words. They are harmless.
- Write: on a rising edge with wen && wready, each channel k with wmask[k]=1 is updated in back[wrow][wcol]. Unmasked channels keep their value.
- A write with wen && !wready is dropped silently; the host must check wready.
- Read: rdata <= front[rrow][rcol] when ren; otherwise rdata holds. Latency is 1 and rvalid <= ren.
- A read on the same edge as a flip uses the pre-flip front.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on clear_req: latch clear_value, zero the row/col counters, set busy=1 and wready=0 from the next cycle.
  - In CLEAR, write the full pixel to back[row][col] once per cycle. col counts 0..COLUMNS-1, then wraps to 0 and row increments.
  - After writing (ROWS-1, COLUMNS-1), return to IDLE: busy=0, wready=1 on the following cycle.
  - A clear takes exactly ROWS*COLUMNS cycles.
  - clear_req while in CLEAR is ignored.
- Flip:
  - flip_req sets flip_pending.
  - On an edge with frame_end && (flip_pending || flip_req) && !busy: front toggles, flip_done pulses for one cycle, and flip_pending clears.
  - If flip_req and frame_end coincide, the flip happens on that edge.
  - frame_end while busy keeps the flip pending; it is applied at the first frame_end after the clear finishes.
  - A flip_req while already pending is merged (no queueing).
  - A clear_req and a flip on the same edge: the clear targets the post-flip back buffer.
- Host writes accepted in the same cycle as a flip land in the pre-flip back buffer.

Decomposition:
- Shared package display_pkg holds: pixel_t (W-bit packed channels), the CHANNELS/CHANNEL_WIDTH defaults, and a clear-FSM state enum {IDLE, CLEAR}.
- One sub-module is natural: framebuffer_ram. It is a simple dual-port RAM with one write port and per-channel byte enables, plus one registered read port, so it maps to block RAM.
- The clear FSM, flip logic and address muxing stay in the top module.

Test Plan:
1. Reset, then write (2,5)=0x112233 with wmask=3'b111, flip_req, then frame_end; read (2,5) -> rdata=0x112233 and rvalid one cycle after ren; front=1; flip_done one pulse.
2. Masked write: back (1,1)=0xAABBCC, then write 0x000000 with wmask=3'b010; flip; read -> 0xAA00CC.
3. Clear with clear_value=0x0F0F0F at defaults -> busy high exactly 256 cycles and wready=0 throughout; a write during that time is dropped; after a flip every one of the 256 reads returns 0x0F0F0F.
4. flip_req during a clear, with frame_end pulsed mid-clear -> front unchanged and flip_pending=1; the first frame_end after busy falls toggles front.
5. Same-edge cases: flip_req with frame_end toggles immediately; ren on the flip edge returns old-front data.
6. Reset asserted mid-clear and mid-pending -> busy=0, wready=1, flip_pending=0, front=0 on the next edge; ROWS=5, COLUMNS=12 clear lasts 60 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and defaults for the double-buffered display framebuffer.
package display_pkg;

    // Default pixel geometry: three 8-bit colour channels.
    localparam int unsigned DefaultChannels     = 3;
    localparam int unsigned DefaultChannelWidth = 8;
    localparam int unsigned DefaultPixelWidth   = DefaultChannels * DefaultChannelWidth;

    // Default-geometry pixel; channel k is pixel[k].
    typedef logic [DefaultChannels-1:0][DefaultChannelWidth-1:0] pixel_t;

    // Clear engine states.
    typedef enum logic {
        StIdle,
        StClear
    } clear_state_e;

endpackage

// File: rtl/framebuffer_ram.sv
// Simple dual-port RAM: one write port with per-channel enables and one
// registered read port. Contents are never reset so it maps onto block RAM.
module framebuffer_ram #(
    parameter int unsigned AW            = 9,
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned CHANNEL_WIDTH = 8,
    localparam int unsigned W            = CHANNELS * CHANNEL_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [W-1:0]        wdata,
    input  logic [CHANNELS-1:0] wbe,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [W-1:0]        rdata
);

    localparam int unsigned Depth = 1 << AW;

    logic [W-1:0] mem [Depth];

    // Write port: only enabled channels of the addressed word change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wbe[k]) begin
                    mem[waddr][k*CHANNEL_WIDTH +: CHANNEL_WIDTH] <=
                        wdata[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                end
            end
        end
    end

    // Registered read port; output holds when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered pixel store: host writes the back buffer, scan-out reads
// the front buffer. Includes a fill engine and a frame-synchronous flip.
module display_framebuffer
    import display_pkg::*;
#(
    parameter int unsigned ROWS          = 8,
    parameter int unsigned COLUMNS       = 32,
    parameter int unsigned CHANNELS      = DefaultChannels,
    parameter int unsigned CHANNEL_WIDTH = DefaultChannelWidth,
    localparam int unsigned W            = CHANNELS * CHANNEL_WIDTH,
    localparam int unsigned RW           = $clog2(ROWS),
    localparam int unsigned CW           = $clog2(COLUMNS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [RW-1:0]       wrow,
    input  logic [CW-1:0]       wcol,
    input  logic [W-1:0]        wdata,
    input  logic [CHANNELS-1:0] wmask,
    output logic                wready,
    input  logic                clear_req,
    input  logic [W-1:0]        clear_value,
    output logic                busy,
    input  logic                flip_req,
    input  logic                frame_end,
    output logic                flip_pending,
    output logic                flip_done,
    output logic                front,
    input  logic                ren,
    input  logic [RW-1:0]       rrow,
    input  logic [CW-1:0]       rcol,
    output logic [W-1:0]        rdata,
    output logic                rvalid
);

    localparam int unsigned AW = 1 + RW + CW;

    clear_state_e  state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [W-1:0]  value_q, value_d;
    logic          front_q, front_d;
    logic          pending_q, pending_d;
    logic          done_q, done_d;
    logic          rvalid_q;
    logic          flip_fire;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [W-1:0]        mem_wdata;
    logic [CHANNELS-1:0] mem_wbe;

    assign busy         = (state_q == StClear);
    assign wready       = ~busy;
    assign front        = front_q;
    assign flip_pending = pending_q;
    assign flip_done    = done_q;
    assign rvalid       = rvalid_q;

    // Clear engine: walk every (row, col) of the back buffer once, col fastest.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        value_d = value_q;
        case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                    row_d   = '0;
                    col_d   = '0;
                    value_d = clear_value;
                end
            end
            StClear: begin
                if (col_q == CW'(COLUMNS - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = StIdle;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Flip is held off while filling so a clear never straddles a swap.
    always_comb begin
        flip_fire = frame_end && (pending_q || flip_req) && !busy;
        front_d   = front_q ^ flip_fire;
        done_d    = flip_fire;
        pending_d = flip_fire ? 1'b0 : (pending_q | flip_req);
    end

    // Write-port mux: the clear engine owns the port while busy. Uses the
    // registered front, so same-edge writes land in the pre-flip back buffer.
    always_comb begin
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = {~front_q, row_q, col_q};
            mem_wdata = value_q;
            mem_wbe   = '1;
        end else begin
            mem_we    = wen;
            mem_waddr = {~front_q, wrow, wcol};
            mem_wdata = wdata;
            mem_wbe   = wmask;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            value_q   <= '0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            value_q   <= value_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            rvalid_q  <= ren;
        end
    end

    framebuffer_ram #(
        .AW            (AW),
        .CHANNELS      (CHANNELS),
        .CHANNEL_WIDTH (CHANNEL_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .wbe   (mem_wbe),
        .re    (ren),
        .raddr ({front_q, rrow, rcol}),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_display_framebuffer.sv
// Bench for display_framebuffer: directed steps plus a randomized phase,
// checked against a per-pixel array model of both buffers.
module tb_display_framebuffer;

    localparam int ROWS = 8;
    localparam int COLS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [2:0]  wrow;
    logic [4:0]  wcol;
    logic [23:0] wdata;
    logic [2:0]  wmask;
    logic        wready;
    logic        clear_req;
    logic [23:0] clear_value;
    logic        busy;
    logic        flip_req;
    logic        frame_end;
    logic        flip_pending;
    logic        flip_done;
    logic        front;
    logic        ren;
    logic [2:0]  rrow;
    logic [4:0]  rcol;
    logic [23:0] rdata;
    logic        rvalid;

    logic        d2_clear_req;
    logic        d2_wready, d2_busy, d2_flip_pending, d2_flip_done, d2_front, d2_rvalid;
    logic [23:0] d2_rdata;

    always #5 clk = ~clk;

    display_framebuffer dut (
        .clk(clk), .rst(rst), .wen(wen), .wrow(wrow), .wcol(wcol), .wdata(wdata),
        .wmask(wmask), .wready(wready), .clear_req(clear_req), .clear_value(clear_value),
        .busy(busy), .flip_req(flip_req), .frame_end(frame_end),
        .flip_pending(flip_pending), .flip_done(flip_done), .front(front), .ren(ren),
        .rrow(rrow), .rcol(rcol), .rdata(rdata), .rvalid(rvalid)
    );

    display_framebuffer #(.ROWS(5), .COLUMNS(12)) dut2 (
        .clk(clk), .rst(rst), .wen(1'b0), .wrow(3'd0), .wcol(4'd0), .wdata(24'd0),
        .wmask(3'd0), .wready(d2_wready), .clear_req(d2_clear_req),
        .clear_value(24'h123456), .busy(d2_busy), .flip_req(1'b0), .frame_end(1'b0),
        .flip_pending(d2_flip_pending), .flip_done(d2_flip_done), .front(d2_front),
        .ren(1'b0), .rrow(3'd0), .rcol(4'd0), .rdata(d2_rdata), .rvalid(d2_rvalid)
    );

    // Reference model
    logic [23:0] m_mem [2][ROWS][COLS];
    int          m_busy;
    bit          m_front, m_pending, m_done, m_rvalid;
    logic [23:0] m_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".busy"},    busy,         m_busy > 0);
        check({where, ".wready"},  wready,       m_busy == 0);
        check({where, ".front"},   front,        m_front);
        check({where, ".pending"}, flip_pending, m_pending);
        check({where, ".done"},    flip_done,    m_done);
        check({where, ".rvalid"},  rvalid,       m_rvalid);
        check({where, ".rdata"},   rdata,        m_rdata);
    endtask

    task automatic model_reset();
        m_busy = 0; m_front = 0; m_pending = 0; m_done = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // One clock: model the edge from the inputs in force, then drop pulses.
    task automatic tick();
        bit fire;
        bit tgt;
        @(posedge clk);
        fire = frame_end && (m_pending || flip_req) && (m_busy == 0);
        if (ren) m_rdata = m_mem[m_front][rrow][rcol];
        m_rvalid = ren;
        if (m_busy == 0 && wen) begin
            for (int k = 0; k < 3; k++)
                if (wmask[k]) m_mem[!m_front][wrow][wcol][k*8 +: 8] = wdata[k*8 +: 8];
        end
        if (m_busy > 0) begin
            m_busy--;
        end else if (clear_req) begin
            m_busy = ROWS * COLS;
            tgt = !(m_front ^ fire);
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) m_mem[tgt][r][c] = clear_value;
        end
        m_done    = fire;
        m_front   = m_front ^ fire;
        m_pending = fire ? 1'b0 : (m_pending | flip_req);
        @(negedge clk);
        wen = 0; clear_req = 0; flip_req = 0; frame_end = 0; ren = 0; d2_clear_req = 0;
    endtask

    task automatic write_px(input int r, input int c, input logic [23:0] d, input logic [2:0] m);
        wen = 1; wrow = 3'(r); wcol = 5'(c); wdata = d; wmask = m;
        tick();
    endtask

    task automatic flip_now();
        flip_req = 1; frame_end = 1;
        tick();
    endtask

    task automatic clear_and_wait(input logic [23:0] v);
        int n;
        clear_req = 1; clear_value = v;
        tick();
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        check("clear_wait", n, ROWS * COLS);
    endtask

    initial begin
        int n;
        logic [23:0] exp_px;
        rst = 1; wen = 0; wrow = 0; wcol = 0; wdata = 0; wmask = 0; clear_req = 0;
        clear_value = 0; flip_req = 0; frame_end = 0; ren = 0; rrow = 0; rcol = 0;
        d2_clear_req = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 0;

        // 1: basic write, flip, read
        write_px(2, 5, 24'h112233, 3'b111);
        flip_req = 1;
        tick();
        check_all("t1.pend");
        frame_end = 1;
        tick();
        check_all("t1.flip");
        check("t1.front", front, 1);
        check("t1.done1", flip_done, 1);
        ren = 1; rrow = 2; rcol = 5;
        tick();
        check_all("t1.read");
        check("t1.rdata", rdata, 24'h112233);
        check("t1.done0", flip_done, 0);
        tick();
        check("t1.rvalid0", rvalid, 0);
        check("t1.hold", rdata, 24'h112233);

        // 3: clear back buffer (0); a write mid-clear is dropped
        clear_req = 1; clear_value = 24'h0F0F0F;
        tick();
        n = 0;
        while (busy && n < 400) begin
            check("t3.wready", wready, 0);
            if (n == 10) begin wen = 1; wrow = 0; wcol = 0; wdata = 24'hDEADBE; wmask = 3'b111; end
            tick();
            n++;
        end
        check("t3.len", n, 256);
        check_all("t3.end");
        flip_now();
        for (int i = 0; i < ROWS * COLS; i++) begin
            ren = 1; rrow = 3'(i / COLS); rcol = 5'(i % COLS);
            tick();
            check("t3.px", rdata, 24'h0F0F0F);
        end

        // 2: masked write into back buffer (1)
        write_px(1, 1, 24'hAABBCC, 3'b111);
        write_px(1, 1, 24'h000000, 3'b010);
        flip_now();
        ren = 1; rrow = 1; rcol = 1;
        tick();
        check("t2.mask", rdata, 24'hAA00CC);
        check_all("t2");

        // 4: flip request during a clear stays pending through frame_end
        clear_req = 1; clear_value = 24'($urandom);
        tick();
        repeat (5) tick();
        flip_req = 1;
        tick();
        repeat (10) tick();
        frame_end = 1;
        tick();
        check_all("t4.mid");
        check("t4.front", front, 1);
        check("t4.pend", flip_pending, 1);
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        check_all("t4.idle");
        frame_end = 1;
        tick();
        check_all("t4.flip");
        check("t4.front2", front, 0);
        clear_and_wait(24'($urandom));

        // 5: same-edge flip with read sees the old front
        rrow = 3'($urandom_range(0, 7)); rcol = 5'($urandom_range(0, 31));
        exp_px = m_mem[m_front][rrow][rcol];
        ren = 1;
        flip_now();
        check("t5.oldfront", rdata, exp_px);
        check_all("t5");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wen = 1'($urandom_range(0, 1)); wrow = 3'($urandom); wcol = 5'($urandom);
            wdata = 24'($urandom); wmask = 3'($urandom);
            ren = 1'($urandom_range(0, 1)); rrow = 3'($urandom); rcol = 5'($urandom);
            flip_req = ($urandom_range(0, 7) == 0);
            frame_end = ($urandom_range(0, 5) == 0);
            clear_req = ($urandom_range(0, 149) == 0);
            clear_value = 24'($urandom);
            tick();
            check_all("rand");
        end
        n = 0;
        while (busy && n < 400) begin tick(); n++; end

        // 6: small geometry clear length
        d2_clear_req = 1;
        tick();
        n = 0;
        while (d2_busy && n < 200) begin tick(); n++; end
        check("t6.len60", n, 60);

        // 6: reset mid-clear with a pending flip
        clear_req = 1; clear_value = 24'h55AA55;
        tick();
        repeat (20) tick();
        flip_req = 1;
        tick();
        frame_end = 1;
        tick();
        check_all("t6.pre");
        #2 rst = 1;
        #1;
        model_reset();
        check("t6.busy", busy, 0);
        check("t6.wready", wready, 1);
        check("t6.pend", flip_pending, 0);
        check("t6.front", front, 0);
        @(negedge clk);
        rst = 0;
        tick();
        check_all("t6.post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
